// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS-style pipeline: default widths, control-bundle bit map
// and the ID/EX occupancy state type.
package mips_pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned CTRL_W_DEF = 9;

  // Control bundle {RegDst, ALUOp[1:0], ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg}
  localparam int unsigned CTRL_REG_DST    = 8;
  localparam int unsigned CTRL_ALU_OP_HI  = 7;
  localparam int unsigned CTRL_ALU_OP_LO  = 6;
  localparam int unsigned CTRL_ALU_SRC    = 5;
  localparam int unsigned CTRL_BRANCH     = 4;
  localparam int unsigned CTRL_MEM_READ   = 3;
  localparam int unsigned CTRL_MEM_WRITE  = 2;
  localparam int unsigned CTRL_REG_WRITE  = 1;
  localparam int unsigned CTRL_MEM_TO_REG = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } idex_state_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// Load-enabled payload register with synchronous active-low clear.
module pipe_payload_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake, one skid entry and synchronous flush.
// Optional IDEX_PERF_CNT_EN adds saturating stall and flush counters.
module id_ex_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
`ifdef IDEX_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_reg1,
  input  logic [DATA_W-1:0] in_reg2,
  input  logic [DATA_W-1:0] in_offset,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_reg1,
  output logic [DATA_W-1:0] out_reg2,
  output logic [DATA_W-1:0] out_offset,
  output logic [REG_AW-1:0] out_rt,
  output logic [REG_AW-1:0] out_rd,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
`endif
);

  localparam int unsigned PayW = 4 * DATA_W + 2 * REG_AW + CTRL_W;

  idex_state_t     state_q, state_d;
  logic [PayW-1:0] in_pay, main_d, main_q, skid_q;
  logic [CTRL_W-1:0] main_ctrl;
  logic            main_load, skid_load;
  logic            accept, deliver;

  assign in_pay  = {in_pc, in_reg1, in_reg2, in_offset, in_rt, in_rd, in_ctrl};
  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    main_d    = in_pay;
    main_load = 1'b0;
    skid_load = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && !deliver) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (accept && deliver) begin
            main_load = 1'b1;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (deliver) begin
            state_d   = ONE;
            main_d    = skid_q;
            main_load = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = reset_n & (state_q != TWO);
    // Bubbles carry all-zero control so they can never write regfile or memory.
    out_ctrl  = out_valid ? main_ctrl : '0;
  end

  pipe_payload_reg #(
    .W (PayW)
  ) u_main_reg (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  pipe_payload_reg #(
    .W (PayW)
  ) u_skid_reg (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .load_i (skid_load),
    .d_i    (in_pay),
    .q_o    (skid_q)
  );

  assign {out_pc, out_reg1, out_reg2, out_offset, out_rt, out_rd, main_ctrl} = main_q;

`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stalled, discarded;

  assign stalled   = out_valid & ~out_ready;
  // A flush in ONE that also delivers hands its entry to EX, so nothing is lost.
  assign discarded = flush & ((state_q == TWO) | ((state_q == ONE) & ~out_ready));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stalled && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (discarded && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Self-checking bench for id_ex_pipe_stage: occupancy model plus FIFO scoreboard of payloads.
module tb_id_ex_pipe_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 9;
  localparam int PW = 4 * DW + 2 * AW + CW;
  localparam int CNTW = 16;

  logic          clock, reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_pc, in_reg1, in_reg2, in_offset, out_pc, out_reg1, out_reg2, out_offset;
  logic [AW-1:0] in_rt, in_rd, out_rt, out_rd;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [PW-1:0] out_word;
`ifdef IDEX_PERF_CNT_EN
  logic [CNTW-1:0] stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] sb_q[$];

  id_ex_pipe_stage dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_reg1    (in_reg1),
    .in_reg2    (in_reg2),
    .in_offset  (in_offset),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_reg1   (out_reg1),
    .out_reg2   (out_reg2),
    .out_offset (out_offset),
    .out_rt     (out_rt),
    .out_rd     (out_rd),
    .out_ctrl   (out_ctrl)
`ifdef IDEX_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  assign out_word = {out_pc, out_reg1, out_reg2, out_offset, out_rt, out_rd, out_ctrl};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [PW-1:0] mk(input logic [DW-1:0] pc);
    logic [DW-1:0] off;
    off = {{16{pc[4]}}, pc[15:0] ^ 16'h0F3C};
    return {pc, pc ^ 32'hA5A5_0000, ~pc, off, pc[6:2], pc[6:2] ^ 5'h1F, pc[10:2] ^ 9'h1B3};
  endfunction

  task automatic drive(input logic v, input logic [PW-1:0] p, input logic ordy, input logic fl);
    in_valid  = v;
    {in_pc, in_reg1, in_reg2, in_offset, in_rt, in_rd, in_ctrl} = p;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Advances one edge and updates the reference model from the inputs seen at that edge.
  task automatic advance();
    logic m_ready, acc, del;
    @(posedge clock);
    m_ready = reset_n && (sb_q.size() < 2);
    acc     = in_valid && m_ready;
    del     = (sb_q.size() > 0) && out_ready;
    if (!reset_n) begin
      sb_q.delete();
    end else begin
      if (del) void'(sb_q.pop_front());
      if (flush) sb_q.delete();
      else if (acc) sb_q.push_back({in_pc, in_reg1, in_reg2, in_offset, in_rt, in_rd, in_ctrl});
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, mk(32'h0000_0040), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      advance();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++;
      if (out_word !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", out_word); end
    end
    reset_n = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] pc;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h100 + 32'(4 * i);
      drive(1'b1, mk(pc), 1'b1, 1'b0);
      advance();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pc) begin
        errors++; $display("FAIL stream_pc: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, pc);
      end
      checks++;
      if (sb_q.size() == 0 || out_word !== sb_q[0]) begin
        errors++; $display("FAIL stream_payload: got %h want %h", out_word, mk(pc));
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    advance();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      errors++; $display("FAIL stream_drain: got v=%b ctrl=%h want v=0 ctrl=0", out_valid, out_ctrl);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, mk(32'h200), 1'b0, 1'b0);
    advance();
    checks++;
    if (out_pc !== 32'h200 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_first: got pc=%h rdy=%b want pc=200 rdy=1", out_pc, in_ready);
    end
    drive(1'b1, mk(32'h204), 1'b0, 1'b0);
    advance();
    checks++;
    if (in_ready !== 1'b0 || out_pc !== 32'h200) begin
      errors++; $display("FAIL bp_full: got rdy=%b pc=%h want rdy=0 pc=200", in_ready, out_pc);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    advance();
    checks++;
    if (out_word !== mk(32'h200)) begin
      errors++; $display("FAIL bp_hold: got %h want %h", out_word, mk(32'h200));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    checks++;
    if (out_pc !== 32'h200 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_release_a: got pc=%h v=%b want pc=200 v=1", out_pc, out_valid);
    end
    advance();
    checks++;
    if (sb_q.size() == 0 || out_word !== sb_q[0] || out_pc !== 32'h204) begin
      errors++; $display("FAIL bp_release_b: got pc=%h want pc=204", out_pc);
    end
    advance();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got v=%b want 0", out_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, mk(32'h300), 1'b0, 1'b0);
    advance();
    drive(1'b1, mk(32'h304), 1'b0, 1'b0);
    advance();
    drive(1'b1, mk(32'h308), 1'b0, 1'b1);
    advance();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: got v=%b ctrl=%h rdy=%b want v=0 ctrl=0 rdy=1",
               out_valid, out_ctrl, in_ready);
    end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL flush_model: got %0d want 0", sb_q.size()); end
`ifdef IDEX_PERF_CNT_EN
    checks++;
    if (flush_count !== 16'd1) begin
      errors++; $display("FAIL flush_count: got %0d want 1", flush_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] pc, prev_pc;
    int bad = 0;
    pc = 32'h1000;
    drive(1'b1, mk(pc), 1'b1, 1'b0);
    advance();
    for (int i = 0; i < 100; i++) begin
      prev_pc = pc;
      pc      = pc + 32'd4;
      drive(1'b1, mk(pc), 1'b1, 1'b0);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_word !== mk(prev_pc)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL b2b_out: got pc=%h rdy=%b want pc=%h rdy=1", out_pc, in_ready, prev_pc);
      end
      advance();
      checks++;
      if (sb_q.size() != 1 || out_word !== sb_q[0]) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL b2b_sb: got pc=%h want pc=%h", out_pc, pc);
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    advance();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got v=%b want 0", out_valid); end
  endtask

`ifdef IDEX_PERF_CNT_EN
  task automatic test_stall_sat();
    drive(1'b1, mk(32'h400), 1'b0, 1'b0);
    advance();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < (1 << CNTW) + 5; i++) advance();
    checks++;
    if (stall_cycles !== {CNTW{1'b1}}) begin
      errors++; $display("FAIL stall_sat: got %h want ffff", stall_cycles);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    advance();
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clock);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
`ifdef IDEX_PERF_CNT_EN
    test_stall_sat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
